// File: rtl/conv_seq_fsm_pkg.sv
// Shared types and constants for the convolution sequencer: state encoding,
// default geometry and the registered flag patterns driven in each state.
package conv_seq_fsm_pkg;

    localparam int NB_ADDRESS_DEF = 10;
    localparam int LATENCY_DEF    = 3;
    localparam int NB_BLK_DEF     = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CHBLK,
        DONE
    } state_t;

    typedef struct packed {
        logic sop;
        logic eop;
        logic chblk;
        logic valid;
        logic ki;
    } flags_t;

    localparam flags_t IDLE_FLAGS  = '{sop: 1'b0, eop: 1'b1, chblk: 1'b0, valid: 1'b0, ki: 1'b1};
    localparam flags_t RUN_FLAGS   = '{sop: 1'b1, eop: 1'b0, chblk: 1'b0, valid: 1'b1, ki: 1'b0};
    localparam flags_t DRAIN_FLAGS = '{sop: 1'b1, eop: 1'b0, chblk: 1'b0, valid: 1'b0, ki: 1'b0};
    localparam flags_t CHBLK_FLAGS = '{sop: 1'b1, eop: 1'b0, chblk: 1'b1, valid: 1'b0, ki: 1'b0};
    localparam flags_t DONE_FLAGS  = '{sop: 1'b0, eop: 1'b1, chblk: 1'b0, valid: 1'b0, ki: 1'b1};

endpackage

// File: rtl/conv_seq_fsm_edge_det.sv
// Rising-edge detector for a GPIO level: pulses for the cycle in which the
// input is high and was low on the previous clock.
module edge_det (
    input  logic CLK100MHZ,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_edge
);

    logic prev;

    // Held high in reset so a level already high at release is not an edge.
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) prev <= 1'b1;
        else          prev <= i_sig;
    end

    assign o_edge = i_sig & ~prev;

endmodule

// File: rtl/conv_seq_fsm.sv
// Address/flag sequencer feeding the MCU and Conv pipeline, block by block.
// Define CONV_SEQ_READBACK_EN to keep DONE and step raddr on i_next_data edges.
module conv_seq_fsm
    import conv_seq_fsm_pkg::*;
#(
    parameter int NB_ADDRESS = NB_ADDRESS_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int NB_BLK     = NB_BLK_DEF
) (
    input  logic                  CLK100MHZ,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_next_data,
    input  logic [NB_ADDRESS-1:0] i_last_addr,
    input  logic [NB_BLK-1:0]     i_nblk,
    output logic [NB_ADDRESS-1:0] o_raddr,
    output logic [NB_ADDRESS-1:0] o_waddr,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_chblk,
    output logic                  o_valid,
    output logic                  o_ki
);

    localparam int NB_LAT = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [NB_ADDRESS-1:0] LAT_A      = NB_ADDRESS'(LATENCY);
    localparam logic [NB_ADDRESS-1:0] ONE_A      = NB_ADDRESS'(1);
    localparam logic [NB_BLK-1:0]     ONE_B      = NB_BLK'(1);
    localparam logic [NB_LAT-1:0]     ONE_L      = NB_LAT'(1);
    localparam logic [NB_LAT-1:0]     DRAIN_LAST = NB_LAT'(LATENCY - 1);

    state_t                state, state_nxt;
    flags_t                flags, flags_nxt;
    logic [NB_ADDRESS-1:0] raddr, raddr_nxt, waddr, waddr_nxt;
    logic [NB_ADDRESS-1:0] last_addr_lat;
    logic [NB_BLK-1:0]     nblk_lat, blk_cnt, blk_cnt_nxt, blk_last;
    logic [NB_LAT-1:0]     drain_cnt, drain_nxt;
    logic [1:0]            rst_pipe;
    logic                  run_en, load_cfg, start_edge, next_edge;

    edge_det u_start_edge (.CLK100MHZ(CLK100MHZ), .i_reset(i_reset), .i_sig(i_start),     .o_edge(start_edge));
    edge_det u_next_edge  (.CLK100MHZ(CLK100MHZ), .i_reset(i_reset), .i_sig(i_next_data), .o_edge(next_edge));

`ifndef CONV_SEQ_READBACK_EN
    logic unused_next_edge;
    assign unused_next_edge = next_edge;
`endif

    // Two-flop release: IDLE cannot be left until reset has been high two clocks.
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign run_en = rst_pipe[1];

    // A block count of zero is treated as a single block.
    assign blk_last = (nblk_lat == '0) ? '0 : nblk_lat - ONE_B;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        flags_nxt   = flags;
        raddr_nxt   = raddr;
        waddr_nxt   = waddr;
        blk_cnt_nxt = blk_cnt;
        drain_nxt   = drain_cnt;
        load_cfg    = 1'b0;
        unique case (state)
            IDLE: begin
                flags_nxt = IDLE_FLAGS;
                raddr_nxt = '0;
                waddr_nxt = '0;
                load_cfg  = start_edge & run_en;
            end
            RUN: begin
                raddr_nxt = raddr + ONE_A;
                waddr_nxt = (raddr >= LAT_A) ? waddr + ONE_A : '0;
                if (raddr == last_addr_lat) begin
                    state_nxt = DRAIN;
                    flags_nxt = DRAIN_FLAGS;
                    raddr_nxt = raddr;
                    drain_nxt = '0;
                end
            end
            DRAIN: begin
                waddr_nxt = waddr + ONE_A;
                drain_nxt = drain_cnt + ONE_L;
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = (blk_cnt == blk_last) ? DONE : CHBLK;
                    flags_nxt = (blk_cnt == blk_last) ? DONE_FLAGS : CHBLK_FLAGS;
                    raddr_nxt = '0;
                    waddr_nxt = '0;
                end
            end
            CHBLK: begin
                state_nxt   = RUN;
                flags_nxt   = RUN_FLAGS;
                raddr_nxt   = '0;
                waddr_nxt   = '0;
                blk_cnt_nxt = blk_cnt + ONE_B;
            end
            DONE: begin
                load_cfg  = start_edge;
                waddr_nxt = '0;
`ifdef CONV_SEQ_READBACK_EN
                if (next_edge) raddr_nxt = raddr + ONE_A;
`else
                state_nxt = IDLE;
                flags_nxt = IDLE_FLAGS;
                raddr_nxt = '0;
`endif
            end
            default: begin
                state_nxt = IDLE;
                flags_nxt = IDLE_FLAGS;
                raddr_nxt = '0;
                waddr_nxt = '0;
            end
        endcase
        // A frame launch overrides everything else, including a readback step.
        if (load_cfg) begin
            state_nxt   = RUN;
            flags_nxt   = RUN_FLAGS;
            raddr_nxt   = '0;
            waddr_nxt   = '0;
            blk_cnt_nxt = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            flags         <= IDLE_FLAGS;
            raddr         <= '0;
            waddr         <= '0;
            blk_cnt       <= '0;
            drain_cnt     <= '0;
            last_addr_lat <= '0;
            nblk_lat      <= '0;
        end else begin
            state     <= state_nxt;
            flags     <= flags_nxt;
            raddr     <= raddr_nxt;
            waddr     <= waddr_nxt;
            blk_cnt   <= blk_cnt_nxt;
            drain_cnt <= drain_nxt;
            if (load_cfg) begin
                last_addr_lat <= i_last_addr;
                nblk_lat      <= i_nblk;
            end
        end
    end

    assign o_raddr = raddr;
    assign o_waddr = waddr;
    assign o_sop   = flags.sop;
    assign o_eop   = flags.eop;
    assign o_chblk = flags.chblk;
    assign o_valid = flags.valid;
    assign o_ki    = flags.ki;

endmodule

// File: doc/conv_seq_fsm.md
CONV_SEQ_FSM -- requirements
Module: conv_seq_fsm

Interface
REQ-001 Parameter NB_ADDRESS, default 10, width of the memory read/write addresses.
REQ-002 Parameter LATENCY, default 3, cycles from read address to matching write address (MCU + Conv pipeline).
REQ-003 Parameter NB_BLK, default 8, width of the column-block counter.
REQ-004 CLK100MHZ  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  level from GPIO; its rising edge launches a frame.
REQ-007 i_next_data  input  1  level from GPIO; its rising edge steps the readback address.
REQ-008 i_last_addr  input  NB_ADDRESS  last read address of a block; latched on the start edge.
REQ-009 i_nblk  input  NB_BLK  number of column blocks per frame; latched on the start edge.
REQ-010 o_raddr / o_waddr  output  NB_ADDRESS each  read / write addresses to the MCU.
REQ-011 o_sop, o_eop, o_chblk  output  1 each  start-of-processing, end-of-processing and change-block flags to the MCU.
REQ-012 o_valid, o_ki  output  1 each  Conv data-valid and kernel/image select (1 = kernel).

Function
REQ-013 Edge detect: rising edge = current input & ~registered previous value; previous registers update every cycle.
REQ-014 States are exactly IDLE, RUN, DRAIN, CHBLK and DONE; all outputs are registered.
REQ-015 IDLE: raddr=0, waddr=0, valid=0, sop=0, eop=1, chblk=0, ki=1; start edge -> RUN, latch i_last_addr and i_nblk, blk_cnt=0.
REQ-016 RUN: sop=1, eop=0, valid=1, ki=0; raddr increments by 1 each cycle starting from 0.
REQ-017 RUN: waddr holds 0 while raddr < LATENCY, then increments by 1 per cycle.
REQ-018 RUN, cycle where raddr == latched last_addr: next state DRAIN; valid=0 from the next cycle.
REQ-019 DRAIN: raddr holds; waddr keeps incrementing for exactly LATENCY cycles, so the final waddr equals last_addr.
REQ-020 DRAIN exit: if blk_cnt == nblk-1 -> DONE, else -> CHBLK.
REQ-021 CHBLK: exactly one cycle with chblk=1, sop=1, valid=0; blk_cnt increments; raddr=0 and waddr=0; -> RUN.
REQ-022 DONE: sop=0, eop=1, valid=0, ki=1; readback behaviour per REQ-029.
REQ-023 A latched nblk of 0 behaves as 1; a latched last_addr of 0 gives a one-cycle RUN.
REQ-024 Start edges in RUN, DRAIN or CHBLK are ignored; in DONE a start edge -> RUN (raddr=0) and takes priority over a simultaneous next_data edge.
REQ-025 Address counters wrap modulo 2^NB_ADDRESS; no overflow flag.

Reset
REQ-026 When i_reset is low: state=IDLE, all outputs at their IDLE values, blk_cnt=0, latched config=0, edge-detect registers=1 so a level high at release produces no edge.
REQ-027 Reset asserted mid-frame aborts immediately with no further write addresses issued.
REQ-028 Reset release is synchronized internally before the FSM leaves IDLE (two-flop release).

Configuration
REQ-029 Macro CONV_SEQ_READBACK_EN defined: DONE persists; each next_data edge increments raddr by 1 (wrap at 2^NB_ADDRESS); waddr holds 0.
REQ-030 Macro CONV_SEQ_READBACK_EN undefined: DONE lasts one cycle then returns to IDLE; i_next_data is unused.

Structure
REQ-031 The shared package holds the state enumeration, default NB_ADDRESS, LATENCY and NB_BLK, and the IDLE output constants.
REQ-032 The rising-edge detector is the single sub-module, edge_det, instantiated once each for i_start and i_next_data.

Verification
REQ-033 last_addr=5, nblk=1, start pulse -> sop high 6+3 cycles, raddr 0..5, waddr 0,0,0,0,1,2 then 3,4,5, eop returns high, valid high exactly 6 cycles.
REQ-034 last_addr=3, nblk=3 -> exactly 2 chblk pulses, each followed by raddr=0; total valid cycles 12; eop asserted once at the end.
REQ-035 Readback enabled, in DONE, 4 next_data edges -> raddr 1,2,3,4; level held high without a new edge -> no change.
REQ-036 Start and next_data edges together in DONE -> RUN with raddr=0; start edge during RUN -> no effect on the sequence.
REQ-037 Reset low at RUN cycle 3 -> all outputs at IDLE values asynchronously; start held high through release -> stays IDLE until a new edge.
REQ-038 Macro undefined -> DONE to IDLE in 1 cycle; next_data toggling -> raddr stays 0.
